alu_responder: RTL and testbench
================================

ALU_RESPONDER -- requirements
Module: alu_responder

Interface
REQ-001 The module SHALL use one clock; reset is synchronous and active-low.
REQ-002 clk  input  1  rising-edge clock; all state SHALL update on the rising edge only.
REQ-003 rst_n  input  1  synchronous active-low reset, sampled on the rising edge of clk.
REQ-004 req_valid  input  1  request present.
REQ-005 req_ready  output  1  responder can accept a request this cycle.
REQ-006 req_a  input  32  operand A.
REQ-007 req_b  input  32  operand B.
REQ-008 req_op  input  3  operation: 0 ADD, 1 SUB, 2 XOR, 3 SLT, 4 AND, 5 NAND, 6 NOR, 7 OR.
REQ-009 req_tag  input  4  requester tag, returned unchanged with the response.
REQ-010 resp_valid  output  1  response present at the head of the buffer.
REQ-011 resp_ready  input  1  consumer accepts the head response.
REQ-012 resp_result  output  32  result R.
REQ-013 resp_carryout  output  1  carry out.
REQ-014 resp_overflow  output  1  signed overflow.
REQ-015 resp_zero  output  1  R == 0.
REQ-016 resp_tag  output  4  tag of the request that produced this response.
REQ-017 resp_count  output  2  buffered responses, 0..2.

Function
REQ-018 Request accept: req_valid && req_ready at a rising edge; response transfer: resp_valid && resp_ready at a rising edge.
REQ-019 Results SHALL be computed from the accepted operands; the result, flags and tag SHALL be written into a 2-entry in-order response FIFO.
REQ-020 ADD: R = A+B mod 2^32; carryout = bit 32 of the sum; overflow = A[31]==B[31] && R[31]!=A[31].
REQ-021 SUB: R = A+~B+1 mod 2^32; carryout = bit 32 of that sum; overflow = A[31]!=B[31] && R[31]!=A[31].
REQ-022 SLT: R = 32'h1 if A < B as signed, else 32'h0; the comparison is the SUB sign bit XOR the SUB overflow.
REQ-023 Logic ops: XOR = A^B, AND = A&B, NAND = ~(A&B), NOR = ~(A|B), OR = A|B.
REQ-024 For SLT and all logic ops, carryout = 0 and overflow = 0.
REQ-025 resp_zero = (R == 0) for every op.
REQ-026 Latency: a request accepted at edge N with an empty FIFO SHALL give resp_valid = 1 with its data after edge N; there is no combinational path from req_* to resp_*.
REQ-027 req_ready = (resp_count < 2); it SHALL depend only on registered state, not on resp_ready.
REQ-028 resp_valid = (resp_count != 0); the head entry SHALL hold all resp_* data stable while resp_valid && !resp_ready.
REQ-029 Simultaneous accept and transfer with count 1 SHALL leave count at 1, with the new entry at the head on the next cycle.
REQ-030 Simultaneous accept and transfer with count 0 SHALL NOT occur, because resp_valid = 0 when the count is 0.
REQ-031 Full (count 2): req_ready = 0 and requests SHALL NOT be accepted; a transfer at count 2 leaves count 1 and req_ready = 1 on the next cycle.
REQ-032 Responses SHALL leave in acceptance order; FIFO pointers SHALL wrap modulo 2.
REQ-033 A request presented while req_ready = 0 SHALL be ignored and SHALL have no side effect.

Reset
REQ-034 While rst_n = 0 at an edge, the module SHALL set resp_count = 0, resp_valid = 0, req_ready = 1, resp_result = 0, resp_carryout = 0, resp_overflow = 0, resp_zero = 0, resp_tag = 0, and reset the pointers.
REQ-035 Reset mid-operation SHALL discard all buffered responses; no response from before reset SHALL appear after reset.
REQ-036 req_valid during a reset cycle SHALL NOT be accepted.

Verification
REQ-037 ADD A=7FFFFFFF, B=7FFFFFFF, tag 3, resp_ready = 1 -> after one cycle R=FFFFFFFE, carryout 0, overflow 1, zero 0, tag 3.
REQ-038 ADD A=90000000, B=80000000 -> R=10000000, carryout 1, overflow 1, zero 0.
REQ-039 ADD A=0000000F, B=FFFFFFF1 -> R=0, carryout 1, zero 1.
REQ-040 SUB A=A7654321, B=71234567 -> R=3641FDBA, overflow 1.
REQ-041 SUB A=B -> R=0, zero 1, carryout 1.
REQ-042 SLT A=FFFFFFFF, B=7FFFFFFF -> R=1.
REQ-043 SLT A=7FFFFFFF, B=FFFFFFFF -> R=0.
REQ-044 NAND A=FFFFFFFF, B=0 -> R=FFFFFFFF, carryout 0, overflow 0.
REQ-045 Backpressure: hold resp_ready = 0 and send 3 requests with tags 1, 2, 3 -> tags 1 and 2 are accepted, resp_count = 2, req_ready = 0, tag 3 is held; then raise resp_ready -> responses return as tags 1, 2, 3 in order, data stable while stalled.
REQ-046 Simultaneous events: with count 1, assert both handshakes for 4 cycles -> count stays 1 and each response matches its request.
REQ-047 Reset with 2 buffered responses -> the next cycle shows resp_valid 0, resp_count 0, req_ready 1, and no stale response afterwards.

Source files
------------

// File: rtl/alu_responder_if.sv
// ---------------------------------------------------------------------------
// alu_responder_if
// Request/response bundle for the ALU responder.
//   Request side : req_valid, req_ready, req_a, req_b, req_op, req_tag
//   Response side: resp_valid, resp_ready, resp_result, resp_carryout,
//                  resp_overflow, resp_zero, resp_tag, resp_count
// Modports:
//   master - the requester/consumer (drives req_* and resp_ready)
//   slave  - the responder (drives req_ready and resp_*)
// ---------------------------------------------------------------------------
interface alu_responder_if #(
    parameter int DATA_W = 32,
    parameter int TAG_W  = 4
);
    logic              req_valid;
    logic              req_ready;
    logic [DATA_W-1:0] req_a;
    logic [DATA_W-1:0] req_b;
    logic [2:0]        req_op;
    logic [TAG_W-1:0]  req_tag;

    logic              resp_valid;
    logic              resp_ready;
    logic [DATA_W-1:0] resp_result;
    logic              resp_carryout;
    logic              resp_overflow;
    logic              resp_zero;
    logic [TAG_W-1:0]  resp_tag;
    logic [1:0]        resp_count;

    modport master (
        output req_valid, req_a, req_b, req_op, req_tag, resp_ready,
        input  req_ready, resp_valid, resp_result, resp_carryout,
               resp_overflow, resp_zero, resp_tag, resp_count
    );

    modport slave (
        input  req_valid, req_a, req_b, req_op, req_tag, resp_ready,
        output req_ready, resp_valid, resp_result, resp_carryout,
               resp_overflow, resp_zero, resp_tag, resp_count
    );
endinterface

// File: rtl/alu_responder.sv
// ---------------------------------------------------------------------------
// alu_responder
// Accepts ALU requests (ADD, SUB, XOR, SLT, AND, NAND, NOR, OR), computes the
// result and flags in the accept cycle and buffers them with the requester
// tag in a 2-entry in-order response FIFO.
// Ports:
//   clk   - rising-edge clock
//   rst_n - synchronous active-low reset
//   bus   - alu_responder_if.slave request/response bundle
// req_ready and all resp_* outputs are derived from registered state only.
// ---------------------------------------------------------------------------
module alu_responder #(
    parameter int DATA_W = 32,
    parameter int TAG_W  = 4
) (
    input  logic           clk,
    input  logic           rst_n,
    alu_responder_if.slave bus
);
    localparam int MSB = DATA_W - 1;

    typedef struct packed {
        logic [DATA_W-1:0] result;
        logic              carry;
        logic              ovf;
        logic              zero;
    } alu_out_t;

    function automatic alu_out_t alu_eval(
        input logic [2:0]               op,
        input logic signed [DATA_W-1:0] a,
        input logic signed [DATA_W-1:0] b
    );
        logic [DATA_W:0] sum;
        logic [DATA_W:0] diff;
        logic            ovf_add;
        logic            ovf_sub;
        alu_out_t        o;
        sum     = {1'b0, a} + {1'b0, b};
        // Subtraction as A + ~B + 1 so bit DATA_W is the "no borrow" carry.
        diff    = {1'b0, a} + {1'b0, ~b} + {{DATA_W{1'b0}}, 1'b1};
        ovf_add = (a[MSB] == b[MSB]) && (sum[MSB] != a[MSB]);
        ovf_sub = (a[MSB] != b[MSB]) && (diff[MSB] != a[MSB]);
        o.result = '0;
        o.carry  = 1'b0;
        o.ovf    = 1'b0;
        case (op)
            3'd0: begin
                o.result = sum[MSB:0];
                o.carry  = sum[DATA_W];
                o.ovf    = ovf_add;
            end
            3'd1: begin
                o.result = diff[MSB:0];
                o.carry  = diff[DATA_W];
                o.ovf    = ovf_sub;
            end
            3'd2: o.result = a ^ b;
            // Signed less-than: sign of A-B corrected by its overflow.
            3'd3: o.result = {{(DATA_W-1){1'b0}}, diff[MSB] ^ ovf_sub};
            3'd4: o.result = a & b;
            3'd5: o.result = ~(a & b);
            3'd6: o.result = ~(a | b);
            default: o.result = a | b;
        endcase
        o.zero = (o.result == '0);
        return o;
    endfunction

    // Stage 0: request accept and ALU evaluation
    logic     accept;
    logic     xfer;
    alu_out_t alu_p0;

    assign accept = bus.req_valid && bus.req_ready;
    assign xfer   = bus.resp_valid && bus.resp_ready;

    always_comb begin
        alu_p0 = alu_eval(bus.req_op, bus.req_a, bus.req_b);
    end

    // Stage 1: response FIFO storage and pointers
    alu_out_t         entry_p1 [2];
    logic [TAG_W-1:0] tag_p1   [2];
    logic             wr_ptr;
    logic             rd_ptr;
    logic [1:0]       count;

    // Storage is not reset; the outputs are masked while the FIFO is empty.
    always_ff @(posedge clk) begin
        if (rst_n && accept) begin
            entry_p1[wr_ptr] <= alu_p0;
            tag_p1[wr_ptr]   <= bus.req_tag;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count  <= 2'd0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
        end else begin
            if (accept) wr_ptr <= ~wr_ptr;
            if (xfer)   rd_ptr <= ~rd_ptr;
            case ({accept, xfer})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

    // Stage 2: head-of-FIFO outputs
    alu_out_t head;
    logic     has_data;

    assign head     = entry_p1[rd_ptr];
    assign has_data = (count != 2'd0);

    assign bus.req_ready     = (count < 2'd2);
    assign bus.resp_valid    = has_data;
    assign bus.resp_count    = count;
    assign bus.resp_result   = has_data ? head.result : '0;
    assign bus.resp_carryout = has_data && head.carry;
    assign bus.resp_overflow = has_data && head.ovf;
    assign bus.resp_zero     = has_data && head.zero;
    assign bus.resp_tag      = has_data ? tag_p1[rd_ptr] : '0;
endmodule

// File: tb/tb_alu_responder.sv
// ---------------------------------------------------------------------------
// tb_alu_responder
// Directed testbench for alu_responder: reset state, each operation with
// hand-computed results and flags, backpressure, simultaneous handshakes
// and reset with buffered responses.
// ---------------------------------------------------------------------------
module tb_alu_responder;
    logic clk;
    logic rst_n;
    int   compared;
    int   mismatched;

    alu_responder_if #(.DATA_W(32), .TAG_W(4)) bus ();

    alu_responder #(.DATA_W(32), .TAG_W(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    // Advance one rising edge; inputs are driven and outputs sampled 1 ns later.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: got %h expected %h", name, obs, exp);
        end
    endtask

    task automatic set_req(input logic v, input logic [2:0] op, input logic [31:0] a,
                           input logic [31:0] b, input logic [3:0] tag);
        bus.req_valid = v;
        bus.req_op    = op;
        bus.req_a     = a;
        bus.req_b     = b;
        bus.req_tag   = tag;
    endtask

    // Single request with an empty FIFO and resp_ready high.
    task automatic do_op(input string name, input logic [2:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [3:0] tag, input logic [31:0] r,
                         input logic c, input logic o, input logic z);
        bus.resp_ready = 1'b1;
        set_req(1'b1, op, a, b, tag);
        step();
        bus.req_valid = 1'b0;
        check({name, ".valid"}, {31'd0, bus.resp_valid}, 32'd1);
        check({name, ".result"}, bus.resp_result, r);
        check({name, ".carry"}, {31'd0, bus.resp_carryout}, {31'd0, c});
        check({name, ".ovf"}, {31'd0, bus.resp_overflow}, {31'd0, o});
        check({name, ".zero"}, {31'd0, bus.resp_zero}, {31'd0, z});
        check({name, ".tag"}, {28'd0, bus.resp_tag}, {28'd0, tag});
        step();
        check({name, ".drain"}, {30'd0, bus.resp_count}, 32'd0);
    endtask

    initial begin
        compared   = 0;
        mismatched = 0;
        rst_n      = 1'b0;
        bus.resp_ready = 1'b0;
        set_req(1'b0, 3'd0, 32'd0, 32'd0, 4'd0);
        step();
        step();
        check("rst.count", {30'd0, bus.resp_count}, 32'd0);
        check("rst.valid", {31'd0, bus.resp_valid}, 32'd0);
        check("rst.ready", {31'd0, bus.req_ready}, 32'd1);
        check("rst.result", bus.resp_result, 32'd0);
        check("rst.flags", {29'd0, bus.resp_carryout, bus.resp_overflow, bus.resp_zero}, 32'd0);
        check("rst.tag", {28'd0, bus.resp_tag}, 32'd0);
        rst_n = 1'b1;
        step();

        do_op("add_ovf",  3'd0, 32'h7FFFFFFF, 32'h7FFFFFFF, 4'd3, 32'hFFFFFFFE, 1'b0, 1'b1, 1'b0);
        do_op("add_cov",  3'd0, 32'h90000000, 32'h80000000, 4'd4, 32'h10000000, 1'b1, 1'b1, 1'b0);
        do_op("add_zero", 3'd0, 32'h0000000F, 32'hFFFFFFF1, 4'd5, 32'h00000000, 1'b1, 1'b0, 1'b1);
        do_op("sub_ovf",  3'd1, 32'hA7654321, 32'h71234567, 4'd6, 32'h3641FDBA, 1'b1, 1'b1, 1'b0);
        do_op("sub_eq",   3'd1, 32'h12345678, 32'h12345678, 4'd7, 32'h00000000, 1'b1, 1'b0, 1'b1);
        do_op("sub_brw",  3'd1, 32'h00000000, 32'h00000001, 4'd8, 32'hFFFFFFFF, 1'b0, 1'b0, 1'b0);
        do_op("slt_t",    3'd3, 32'hFFFFFFFF, 32'h7FFFFFFF, 4'd9, 32'h00000001, 1'b0, 1'b0, 1'b0);
        do_op("slt_f",    3'd3, 32'h7FFFFFFF, 32'hFFFFFFFF, 4'd10, 32'h00000000, 1'b0, 1'b0, 1'b1);
        do_op("nand",     3'd5, 32'hFFFFFFFF, 32'h00000000, 4'd11, 32'hFFFFFFFF, 1'b0, 1'b0, 1'b0);
        do_op("xor",      3'd2, 32'h0F0F0F0F, 32'hFF00FF00, 4'd12, 32'hF00FF00F, 1'b0, 1'b0, 1'b0);
        do_op("and",      3'd4, 32'hF0F0F0F0, 32'h3C3C3C3C, 4'd13, 32'h30303030, 1'b0, 1'b0, 1'b0);
        do_op("nor",      3'd6, 32'h00000000, 32'h00000000, 4'd14, 32'hFFFFFFFF, 1'b0, 1'b0, 1'b0);
        do_op("or",       3'd7, 32'h12340000, 32'h00005678, 4'd15, 32'h12345678, 1'b0, 1'b0, 1'b0);

        // Backpressure: tags 1 and 2 fill the FIFO, tag 3 is held off.
        bus.resp_ready = 1'b0;
        set_req(1'b1, 3'd0, 32'd1, 32'd1, 4'd1);
        step();
        check("bp.count1", {30'd0, bus.resp_count}, 32'd1);
        set_req(1'b1, 3'd0, 32'd2, 32'd2, 4'd2);
        step();
        check("bp.count2", {30'd0, bus.resp_count}, 32'd2);
        check("bp.ready0", {31'd0, bus.req_ready}, 32'd0);
        set_req(1'b1, 3'd0, 32'd3, 32'd3, 4'd3);
        for (int i = 0; i < 2; i++) begin
            step();
            check("bp.hold_count", {30'd0, bus.resp_count}, 32'd2);
            check("bp.hold_tag", {28'd0, bus.resp_tag}, 32'd1);
            check("bp.hold_result", bus.resp_result, 32'd2);
        end
        bus.resp_ready = 1'b1;
        step();
        check("bp.after1_count", {30'd0, bus.resp_count}, 32'd1);
        check("bp.after1_tag", {28'd0, bus.resp_tag}, 32'd2);
        check("bp.after1_result", bus.resp_result, 32'd4);
        check("bp.after1_ready", {31'd0, bus.req_ready}, 32'd1);
        step();
        bus.req_valid = 1'b0;
        check("bp.after2_count", {30'd0, bus.resp_count}, 32'd1);
        check("bp.after2_tag", {28'd0, bus.resp_tag}, 32'd3);
        check("bp.after2_result", bus.resp_result, 32'd6);
        step();
        check("bp.drain", {30'd0, bus.resp_count}, 32'd0);

        // Simultaneous accept and transfer at count 1.
        bus.resp_ready = 1'b0;
        set_req(1'b1, 3'd7, 32'd8, 32'h100, 4'd8);
        step();
        check("sim.count_init", {30'd0, bus.resp_count}, 32'd1);
        bus.resp_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            set_req(1'b1, 3'd7, 32'(i + 1), 32'h100, 4'(9 + i));
            step();
            check("sim.count", {30'd0, bus.resp_count}, 32'd1);
            check("sim.tag", {28'd0, bus.resp_tag}, 32'(9 + i));
            check("sim.result", bus.resp_result, 32'(i + 1) | 32'h100);
        end
        bus.req_valid = 1'b0;
        step();
        check("sim.drain", {30'd0, bus.resp_count}, 32'd0);

        // Reset with two buffered responses and a request pending.
        bus.resp_ready = 1'b0;
        set_req(1'b1, 3'd0, 32'd5, 32'd5, 4'd5);
        step();
        set_req(1'b1, 3'd0, 32'd6, 32'd6, 4'd6);
        step();
        check("mrst.pre_count", {30'd0, bus.resp_count}, 32'd2);
        set_req(1'b1, 3'd0, 32'd7, 32'd7, 4'd7);
        rst_n = 1'b0;
        step();
        check("mrst.valid", {31'd0, bus.resp_valid}, 32'd0);
        check("mrst.count", {30'd0, bus.resp_count}, 32'd0);
        check("mrst.ready", {31'd0, bus.req_ready}, 32'd1);
        check("mrst.result", bus.resp_result, 32'd0);
        check("mrst.tag", {28'd0, bus.resp_tag}, 32'd0);
        rst_n = 1'b1;
        bus.req_valid = 1'b0;
        bus.resp_ready = 1'b1;
        step();
        check("mrst.post_count", {30'd0, bus.resp_count}, 32'd0);
        check("mrst.post_valid", {31'd0, bus.resp_valid}, 32'd0);
        step();
        check("mrst.stale", {31'd0, bus.resp_valid}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
